seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Display sequencer for the 4-digit multiplexed 7-segment LED board. It consumes the single-cycle debounced key strobe from the key front end and owns a 4-digit BCD counter driven by a three-state run/hold/stop FSM. It time-multiplexes the counter onto the common-anode digit drivers using an internal scan divider.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; scan tick period. Must be ≥ 2.
- STEP_TICKS, 100: scan ticks per counter increment while running. Must be ≥ 1.
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset.
- key_pulse  input  1  debounced press strobe, one clk wide, synchronous to clk.
- an  output  4  digit enables, active-low; an[i]=0 selects digit i (digit 0 = least significant).
- seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- mode  output  2  FSM state: 00 STOP, 01 RUN, 10 HOLD.
- count_bcd  output  16  counter value, 4 BCD nibbles, [3:0] = digit 0.

## Operation
- Scan divider: scan_cnt counts 0..SCAN_DIV-1 and wraps; scan_tick = (scan_cnt == SCAN_DIV-1), one clk wide.
- Digit scan: 2-bit idx. On scan_tick, an/seg load for the current idx, then idx increments mod 4. The scan runs in every mode.
- Segment codes (bits 6:0 shown with dp off):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - Blank: FF.
- Leading-zero blanking: digit i>0 is blank when its nibble and all higher nibbles are 0. Digit 0 is never blanked.
- Decimal point: seg[7]=0 only on digit 0 while mode=HOLD; otherwise seg[7]=1.
- FSM, advanced by key_pulse only:
  - STOP→RUN: step_cnt cleared.
  - RUN→HOLD: count and step_cnt frozen.
  - HOLD→STOP: count_bcd and step_cnt cleared to 0.
- Stepping in RUN: on each scan_tick, step_cnt increments. At step_cnt == STEP_TICKS-1, step_cnt goes to 0 and count_bcd increments by one in BCD with per-nibble carry. 9999 wraps to 0000.
- Counter nibbles never hold values >9.

## Timing
- Reset values:
  - an=F, seg=FF, mode=00, count_bcd=0000, idx=0, scan_cnt=0, step_cnt=0.
- First scan_tick occurs SCAN_DIV-1 cycles after reset release. an/seg change on the following edge: an=E with digit 0 code.
- key_pulse at edge N: mode reflects the new state at edge N+1. Displayed dp changes at the next scan_tick that serves digit 0.
- Increment: count_bcd updates one cycle after the qualifying scan_tick.
- Simultaneous key_pulse and increment condition: the key wins.
  - RUN→HOLD: the increment is dropped.
  - STOP/HOLD cases: no increment, since the mode is not RUN.
- A counter change mid-frame shows on each digit at its next slot. No frame-coherence requirement.
- Reset mid-operation forces all reset values immediately (asynchronous assert). Recovery is on the first edge after deassert.
- key_pulse asserted for more than one cycle is out of contract. Each asserted cycle counts as one press.

## Test plan
- Reset release, SCAN_DIV=4: an stays F for 3 cycles. Then an=E, seg=C0, then D/FF, B/FF, 7/FF, E/C0 every 4 cycles.
- SCAN_DIV=4, STEP_TICKS=2, one key_pulse: mode=01. count_bcd reaches 0001 at the 2nd scan tick after entry and 0002 at the 4th. Digit 0 shows F9 then A4; digits 1-3 blank.
- Preload by running to 0099, then continue: next step gives 0100. Frame shows digit2=F9, digit1=C0, digit0=C0, digit3 blank. 9999 +1 → 0000, with only digit 0 showing C0.
- RUN, press: mode=10, count frozen for 20 scan ticks, digit 0 seg=seg code with bit7 cleared (e.g. 0005 → 12). Press again: mode=00, count_bcd=0000, dp off.
- key_pulse on the same cycle as a qualifying increment in RUN: mode=10, count_bcd unchanged.
- Assert rst while RUN at count 0042 mid-slot: an=F, seg=FF, mode=00, count_bcd=0000 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// seg_scan_ctrl
// Display sequencer for the 4-digit multiplexed common-anode 7-segment board.
// A three-state FSM (STOP/RUN/HOLD), advanced by a one-cycle key strobe,
// owns a 4-digit BCD counter. The counter steps every STEP_TICKS scan ticks
// while running. A free-running scan divider multiplexes the counter onto
// the digit drivers, one digit slot every SCAN_DIV clocks.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   key_pulse  debounced press strobe, one clk wide
//   an[3:0]    digit enables, active-low, an[i]=0 selects digit i
//   seg[7:0]   segments, active-low, {dp,g,f,e,d,c,b,a}
//   mode[1:0]  FSM state: 00 STOP, 01 RUN, 10 HOLD
//   count_bcd  counter value, four BCD nibbles, [3:0] = digit 0
module seg_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,  // clk cycles per digit slot, >= 2
  parameter int STEP_TICKS = 100     // scan ticks per count step, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  mode,
  output logic [15:0] count_bcd
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  // A single-tick step still needs a one-bit counter to keep widths legal.
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t             state_reg, state_next;
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [1:0]         idx_reg;
  logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;
  logic [15:0]        count_reg, count_next;
  logic [3:0]         an_reg, an_next;
  logic [7:0]         seg_reg, seg_next;

  logic               scan_tick;
  logic [3:0]         nib [4];
  logic [15:0]        count_inc;   // count_reg + 1 in BCD, 9999 wraps to 0000
  logic [3:0]         carry;       // carry[i]: the increment reaches nibble i
  logic [3:1]         upper_zero;  // upper_zero[i]: nibbles i..3 are all zero
  logic [3:0]         blank;       // leading-zero blanking per digit
  logic [3:0]         nib_sel;
  logic               blank_sel;

  assign scan_tick = (scan_cnt_reg == SCAN_LAST);

  // Per-digit BCD increment and leading-zero detection.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign nib[gi] = count_reg[gi*4 +: 4];
      assign count_inc[gi*4 +: 4] =
        carry[gi] ? ((nib[gi] == 4'd9) ? 4'd0 : nib[gi] + 4'd1) : nib[gi];

      if (gi == 0) begin : g_lsd
        assign carry[gi] = 1'b1;
        assign blank[gi] = 1'b0;  // digit 0 always shows, even for 0000
      end else begin : g_upper
        assign carry[gi] = carry[gi-1] & (nib[gi-1] == 4'd9);
        assign blank[gi] = upper_zero[gi];
      end

      if (gi == 3) begin : g_msd
        assign upper_zero[gi] = (nib[gi] == 4'd0);
      end else if (gi > 0) begin : g_mid
        assign upper_zero[gi] = (nib[gi] == 4'd0) & upper_zero[gi+1];
      end
    end
  endgenerate

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign nib_sel   = nib[idx_reg];
  assign blank_sel = blank[idx_reg];

  // Pattern for the slot currently being served. The decimal point lights
  // on digit 0 only while the counter is held.
  always_comb begin
    an_next       = ~(4'b0001 << idx_reg);
    seg_next[6:0] = blank_sel ? 7'h7F : seg_code(nib_sel);
    seg_next[7]   = ~((idx_reg == 2'd0) && (state_reg == ST_HOLD));
  end

  // Scan divider and digit drivers; the scan runs in every mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_reg <= '0;
      idx_reg      <= 2'd0;
      an_reg       <= 4'hF;
      seg_reg      <= 8'hFF;
    end else if (scan_tick) begin
      scan_cnt_reg <= '0;
      idx_reg      <= idx_reg + 2'd1;
      an_reg       <= an_next;
      seg_reg      <= seg_next;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  // Mode FSM and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_STOP;
      step_cnt_reg <= '0;
      count_reg    <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      step_cnt_reg <= step_cnt_next;
      count_reg    <= count_next;
    end
  end

  // A key press takes priority over a step that lands on the same cycle.
  always_comb begin
    state_next    = state_reg;
    step_cnt_next = step_cnt_reg;
    count_next    = count_reg;
    case (state_reg)
      ST_STOP: begin
        if (key_pulse) begin
          state_next    = ST_RUN;
          step_cnt_next = '0;
        end
      end
      ST_RUN: begin
        if (key_pulse) begin
          state_next = ST_HOLD;
        end else if (scan_tick) begin
          if (step_cnt_reg == STEP_LAST) begin
            step_cnt_next = '0;
            count_next    = count_inc;
          end else begin
            step_cnt_next = step_cnt_reg + STEP_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (key_pulse) begin
          state_next    = ST_STOP;
          step_cnt_next = '0;
          count_next    = 16'h0000;
        end
      end
      default: begin
        state_next    = ST_STOP;
        step_cnt_next = '0;
        count_next    = 16'h0000;
      end
    endcase
  end

  assign an        = an_reg;
  assign seg       = seg_reg;
  assign mode      = state_reg;
  assign count_bcd = count_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with a small, fast configuration.
// A behavioural model (integer counter, decimal digit arithmetic) pushes the
// expected display slot, mode change and count change, stamped with the
// edge time, into queues. A separate monitor pops an entry whenever the DUT
// output changes and compares value and timing. Point checks (reset, hold,
// key priority) are queued as snapshots and compared by the same monitor.
module tb_seg_scan_ctrl;

  localparam int SD   = 3;   // SCAN_DIV
  localparam int ST   = 2;   // STEP_TICKS
  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_pulse = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [1:0]  mode;
  logic [15:0] count_bcd;

  seg_scan_ctrl #(.SCAN_DIV(SD), .STEP_TICKS(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .an        (an),
    .seg       (seg),
    .mode      (mode),
    .count_bcd (count_bcd)
  );

  always #HALF clk = ~clk;

  typedef struct packed {
    logic [63:0] t;
    logic [3:0]  an;
    logic [7:0]  seg;
  } disp_t;

  typedef struct packed {
    logic [63:0] t;
    logic [15:0] val;
  } val_t;

  typedef struct packed {
    logic        chk_disp;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  mode;
    logic [15:0] cnt;
  } snap_t;

  disp_t disp_q[$];
  val_t  mode_q[$];
  val_t  cnt_q[$];
  snap_t snap_q[$];
  string snap_name_q[$];
  event  snap_ev;
  bit    done = 1'b0;
  int    timeouts = 0;
  int    checks = 0;
  int    errors = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int pow10 [4] = '{1, 10, 100, 1000};

  // Reference model state: edges since reset release, mode, decimal count.
  int k = 0;
  int m_mode = 0;   // 0 STOP, 1 RUN, 2 HOLD
  int m_count = 0;
  int m_step = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(input int slot, input int cnt, input int md);
    logic [7:0] b;
    if (slot > 0 && cnt < pow10[slot]) b = 8'hFF;
    else b = seg_tab[(cnt / pow10[slot]) % 10];
    if (slot == 0 && md == 2) b[7] = 1'b0;
    return b;
  endfunction

  // Behavioural model: a scan slot completes every SD-th edge after release.
  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst) begin
        k = 0; m_mode = 0; m_count = 0; m_step = 0;
      end else begin
        int    old_cnt;
        int    slot;
        bit    tick;
        disp_t d;
        val_t  v;
        k++;
        tick    = (k % SD == 0);
        old_cnt = m_count;
        if (tick) begin
          slot  = (k / SD - 1) % 4;
          d.t   = $time;
          d.an  = 4'hF ^ (4'b0001 << slot);
          d.seg = exp_seg(slot, m_count, m_mode);
          disp_q.push_back(d);
        end
        if (key_pulse) begin
          case (m_mode)
            0:       begin m_mode = 1; m_step = 0; end
            1:       m_mode = 2;
            default: begin m_mode = 0; m_count = 0; m_step = 0; end
          endcase
          v.t = $time; v.val = 16'(m_mode);
          mode_q.push_back(v);
        end else if (m_mode == 1 && tick) begin
          m_step++;
          if (m_step == ST) begin
            m_step  = 0;
            m_count = (m_count + 1) % 10000;
          end
        end
        if (m_count != old_cnt) begin
          v.t = $time; v.val = to_bcd(m_count);
          cnt_q.push_back(v);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: the only process that compares and counts.
  initial begin : monitor
    logic [3:0]  p_an;
    logic [7:0]  p_seg;
    logic [1:0]  p_mode;
    logic [15:0] p_cnt;
    p_an = 4'hF; p_seg = 8'hFF; p_mode = 2'b00; p_cnt = 16'h0000;
    forever begin
      @(negedge clk or snap_ev);
      while (snap_q.size() > 0) begin
        snap_t s;
        string nm;
        s  = snap_q.pop_front();
        nm = snap_name_q.pop_front();
        if (s.chk_disp) begin
          chk({nm, "_an"}, 64'(an), 64'(s.an));
          chk({nm, "_seg"}, 64'(seg), 64'(s.seg));
        end
        chk({nm, "_mode"}, 64'(mode), 64'(s.mode));
        chk({nm, "_count"}, 64'(count_bcd), 64'(s.cnt));
      end
      if (rst) begin
        if (an !== p_an || seg !== p_seg) begin
          if (disp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL disp_unexpected: got an=%h seg=%h, expected no change", an, seg);
          end else begin
            disp_t d;
            d = disp_q.pop_front();
            chk("disp_an", 64'(an), 64'(d.an));
            chk("disp_seg", 64'(seg), 64'(d.seg));
            chk("disp_time", $time, d.t + HALF);
          end
        end
        if (mode !== p_mode) begin
          if (mode_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mode_unexpected: got %h, expected no change", mode);
          end else begin
            val_t v;
            v = mode_q.pop_front();
            chk("mode_val", 64'(mode), 64'(v.val));
            chk("mode_time", $time, v.t + HALF);
          end
        end
        if (count_bcd !== p_cnt) begin
          if (cnt_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL count_unexpected: got %h, expected no change", count_bcd);
          end else begin
            val_t v;
            v = cnt_q.pop_front();
            chk("count_val", 64'(count_bcd), 64'(v.val));
            chk("count_time", $time, v.t + HALF);
          end
        end
      end
      p_an = an; p_seg = seg; p_mode = mode; p_cnt = count_bcd;
      if (done) begin
        chk("disp_q_drained", 64'(disp_q.size()), 64'd0);
        chk("mode_q_drained", 64'(mode_q.size()), 64'd0);
        chk("cnt_q_drained", 64'(cnt_q.size()), 64'd0);
        chk("wait_timeouts", 64'(timeouts), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  task automatic snap(input string nm, input bit cd, input logic [3:0] a,
                      input logic [7:0] s, input logic [1:0] md, input logic [15:0] c);
    snap_t x;
    x.chk_disp = cd; x.an = a; x.seg = s; x.mode = md; x.cnt = c;
    snap_q.push_back(x);
    snap_name_q.push_back(nm);
    -> snap_ev;
  endtask

  task automatic press();
    @(negedge clk);
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    $display("key press at %0t: mode %0d count %0d", $time, m_mode, m_count);
  endtask

  task automatic wait_count(input int target, input int budget);
    int n = 0;
    while (m_count != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_count != target) begin
      timeouts++;
      $display("timeout waiting for count %0d", target);
    end
  endtask

  initial begin : stimulus
    int c;
    int n;
    #1 rst = 1'b0;
    #1 snap("reset", 1'b1, 4'hF, 8'hFF, 2'b00, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);                 // idle scan in STOP

    press();                                    // STOP -> RUN
    wait_count(99, 2000);
    wait_count(100, 100);
    repeat (4 * SD + 2) @(negedge clk);         // full frame of 0100
    wait_count(105, 200);

    press();                                    // RUN -> HOLD
    #1 snap("hold_entry", 1'b0, 4'h0, 8'h00, 2'b10, 16'h0105);
    repeat (SD * 20) @(negedge clk);
    #1 snap("hold_frozen", 1'b0, 4'h0, 8'h00, 2'b10, 16'h0105);
    press();                                    // HOLD -> STOP
    #1 snap("stop_clear", 1'b0, 4'h0, 8'h00, 2'b00, 16'h0000);
    repeat (12) @(negedge clk);

    // Key on the very cycle a step would land.
    press();                                    // STOP -> RUN
    n = 0;
    while (!(((k + 1) % SD == 0) && m_step == ST - 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeouts++;
    c = m_count;
    key_pulse = 1'b1;
    @(negedge clk);
    key_pulse = 1'b0;
    $display("key press at %0t on a step cycle: mode %0d count %0d", $time, m_mode, m_count);
    #1 snap("key_wins", 1'b0, 4'h0, 8'h00, 2'b10, to_bcd(c));
    press();                                    // HOLD -> STOP

    // Random single-cycle presses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (key_pulse) begin
        key_pulse = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        key_pulse = 1'b1;
        $display("random key press at %0t: mode before %0d count %0d", $time, m_mode, m_count);
      end
    end
    @(negedge clk);
    key_pulse = 1'b0;

    // Full wrap 9999 -> 0000.
    for (int i = 0; i < 3 && m_mode != 0; i++) press();
    press();                                    // STOP -> RUN
    wait_count(9999, 70000);
    wait_count(0, 100);
    repeat (4 * SD + 2) @(negedge clk);

    // Asynchronous reset mid-slot while running at 0042.
    wait_count(42, 1000);
    #1 rst = 1'b0;
    #1 snap("async_reset", 1'b1, 4'hF, 8'hFF, 2'b00, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    press();                                    // recovery: STOP -> RUN
    repeat (40) @(negedge clk);

    #2 done = 1'b1;
    -> snap_ev;
  end

endmodule
